// File: rtl/game_trigger_counter.sv
// rtl/game_trigger_counter.sv - multimode up/down game counter emitting winner/loser trigger pulses
// Optional feature macro: COUNTER_PAUSE_EN (adds the pause input)
module game_trigger_counter #(
  parameter int unsigned          WIDTH        = 4,
  parameter logic [WIDTH-1:0]     INIT_DEFAULT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             init,
  input  logic [WIDTH-1:0] init_value,
  input  logic             gameover,
`ifdef COUNTER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             winner,
  output logic             loser,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             winner_q, winner_d;
  logic             loser_q, loser_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] stepped;
  logic             paused;

  // mode[0] selects a step of two, mode[1] selects counting down; wrap is modulo 2^WIDTH
  assign step_val = mode[0] ? WIDTH'(2) : WIDTH'(1);
  assign stepped  = mode[1] ? (count_q - step_val) : (count_q + step_val);

`ifdef COUNTER_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Next-state, next-count and pulse decode; init beats gameover beats pause beats stepping
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    winner_d = 1'b0;
    loser_d  = 1'b0;
    if (init) begin
      state_d = RUN;
      count_d = init_value;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (gameover) begin
            state_d = HALT;
          end else if (!paused) begin
            count_d  = stepped;
            winner_d = (stepped == MAX_COUNT);
            loser_d  = (stepped == '0);
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, count and pulse registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= INIT_DEFAULT;
      winner_q <= 1'b0;
      loser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      loser_q  <= loser_d;
    end
  end

  assign count   = count_q;
  assign winner  = winner_q;
  assign loser   = loser_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_game_trigger_counter.sv
// tb/tb_game_trigger_counter.sv - scoreboard testbench for game_trigger_counter
module tb_game_trigger_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       init;
  logic [3:0] init_value;
  logic       gameover;
`ifdef COUNTER_PAUSE_EN
  logic       pause;
`endif
  logic [3:0] count;
  logic       winner;
  logic       loser;
  logic       running;

  int checks = 0;
  int errors = 0;

  // expected {count, winner, loser, running}
  logic [6:0] sb[$];
  logic [6:0] obs;
  logic [6:0] e;

  // reference model state: 0 idle, 1 run, 2 halt
  int m_count;
  int m_state;

  assign obs = {count, winner, loser, running};

  game_trigger_counter #(
    .WIDTH(4),
    .INIT_DEFAULT(4'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .init(init),
    .init_value(init_value),
    .gameover(gameover),
`ifdef COUNTER_PAUSE_EN
    .pause(pause),
`endif
    .count(count),
    .winner(winner),
    .loser(loser),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // stimulus word: {start, mode[1:0], init, init_value[3:0], gameover, pause}
  function automatic logic [9:0] vec(input logic s, input logic [1:0] md, input logic in,
                                     input logic [3:0] iv, input logic go, input logic ps);
    return {s, md, in, iv, go, ps};
  endfunction

  // apply one cycle of stimulus, push the model's expectation, and advance past the edge
  task automatic drive(input logic [9:0] x);
    int  stp;
    logic w, l, ps_eff;
    @(negedge clk);
    start      = x[9];
    mode       = x[8:7];
    init       = x[6];
    init_value = x[5:2];
    gameover   = x[1];
`ifdef COUNTER_PAUSE_EN
    pause      = x[0];
    ps_eff     = x[0];
`else
    ps_eff     = 1'b0;
`endif
    w = 1'b0;
    l = 1'b0;
    if (x[6]) begin
      m_count = int'(x[5:2]);
      m_state = 1;
    end else if (m_state == 1) begin
      if (x[1]) begin
        m_state = 2;
      end else if (!ps_eff) begin
        stp = x[7] ? 2 : 1;
        if (x[8]) m_count = (m_count + 16 - stp) % 16;
        else      m_count = (m_count + stp) % 16;
        w = (m_count == 15);
        l = (m_count == 0);
      end
    end else if (m_state == 0 && x[9]) begin
      m_state = 1;
    end
    sb.push_back({m_count[3:0], w, l, (m_state == 1)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] v[$];
    rst = 1'b0; start = 0; mode = 0; init = 0; init_value = 0; gameover = 0;
`ifdef COUNTER_PAUSE_EN
    pause = 0;
`endif
    m_count = 0;
    m_state = 0;
    #3;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_asserted: got %b expected %b (count,winner,loser,running)", obs, 7'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_idle_hold[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_start();
    logic [9:0] v[$];
    v.push_back(vec(1, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(1, 2'b10, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL start[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_count_up();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b00, 1, 4'd13, 0, 0));
    for (int k = 0; k < 4; k++) v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL count_up[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_count_down2();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b11, 1, 4'd3, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(vec(0, 2'b11, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL count_down2[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_gameover();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b00, 1, 4'd5, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 1, 0));
    v.push_back(vec(1, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b01, 0, 4'd0, 1, 0));
    v.push_back(vec(0, 2'b00, 1, 4'd2, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL gameover[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_priority_wrap();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b00, 1, 4'd9, 1, 0));
    v.push_back(vec(0, 2'b10, 1, 4'd1, 0, 0));
    v.push_back(vec(0, 2'b10, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b01, 1, 4'd14, 0, 0));
    v.push_back(vec(0, 2'b01, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 1, 4'd15, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL priority_wrap[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b00, 1, 4'd14, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_pre[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b (count,winner,loser,running)", obs, 7'b0);
    end
    m_count = 0;
    m_state = 0;
    @(negedge clk);
    rst = 1'b1;
    v.delete();
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(1, 2'b00, 0, 4'd0, 0, 0));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL async_post[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask

`ifdef COUNTER_PAUSE_EN
  task automatic test_pause();
    logic [9:0] v[$];
    v.push_back(vec(0, 2'b00, 1, 4'd14, 0, 0));
    for (int k = 0; k < 3; k++) v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 1));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 0, 0));
    v.push_back(vec(0, 2'b00, 0, 4'd0, 1, 1));
    v.push_back(vec(0, 2'b00, 1, 4'd4, 0, 1));
    foreach (v[k]) begin
      drive(v[k]);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pause[%0d]: got %b expected %b (count,winner,loser,running)", k, obs, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_count_up();
    test_count_down2();
    test_gameover();
    test_priority_wrap();
    test_async_reset();
`ifdef COUNTER_PAUSE_EN
    test_pause();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
